// File: rtl/alu_issue_ctrl.sv
//------------------------------------------------------------------------------
// alu_issue_ctrl : one-command-at-a-time sequencer for reg_file + alu
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;
    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5
    } alu_op_t;
endpackage

module alu_issue_ctrl #(
    parameter int REG_DEPTH = 16,
    parameter int REG_WIDTH = 64,
    parameter int IMM_WIDTH = 16,
    parameter int ALU_LAT   = 1,
    parameter int ZERO_REG  = 1,
    localparam int REG_ADDRW = $clog2(REG_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_kind,
    input  alu_pkg::alu_op_t      cmd_op,
    input  logic [REG_ADDRW-1:0]  cmd_a,
    input  logic [REG_ADDRW-1:0]  cmd_b,
    input  logic [REG_ADDRW-1:0]  cmd_d,
    input  logic [IMM_WIDTH-1:0]  cmd_imm,
    output logic [REG_ADDRW-1:0]  rf_addr_out0,
    output logic [REG_ADDRW-1:0]  rf_addr_out1,
    output logic                  rf_en_in,
    output logic [REG_ADDRW-1:0]  rf_addr_in,
    output logic [REG_WIDTH-1:0]  rf_data_in,
    output alu_pkg::alu_op_t      alu_op,
    input  logic [REG_WIDTH-1:0]  alu_res,
    input  logic                  alu_zf,
    input  logic                  alu_cf,
    input  logic                  alu_of,
    input  logic                  alu_sf,
    output logic [3:0]            flags,
    output logic                  done,
    output logic                  busy
);
    import alu_pkg::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);

    state_t               state;
    state_t               state_n;
    logic                 accept;
    logic [1:0]           wait_cnt;
    alu_op_t              op_q;
    logic [REG_ADDRW-1:0] d_q;
    logic                 wait_last;
    logic [REG_WIDTH-1:0] imm_ext;

    function automatic logic dest_ok(input logic [REG_ADDRW-1:0] d);
        return (ZERO_REG == 0) || (d != '0);
    endfunction

    assign wait_last = (state == WAIT) && (wait_cnt == 2'd0);
    assign imm_ext   = REG_WIDTH'($signed(cmd_imm));

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_n = cmd_kind ? WB : ISSUE;
                end
            end
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = (wait_cnt == 2'd0) ? WB : WAIT;
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
            op_q     <= ALU_NOP;
            d_q      <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q <= cmd_op;
                d_q  <= cmd_d;
            end
            if (state == ISSUE) begin
                wait_cnt <= CNT_INIT;
            end else if ((state == WAIT) && (wait_cnt != 2'd0)) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
        end
    end

    // Outputs are registered from the next-state decode so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            alu_op       <= ALU_NOP;
            rf_en_in     <= 1'b0;
            rf_addr_in   <= '0;
            rf_data_in   <= '0;
            rf_addr_out0 <= '0;
            rf_addr_out1 <= '0;
            flags        <= 4'd0;
        end else begin
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
            done      <= (state_n == WB);
            alu_op    <= ALU_NOP;
            rf_en_in  <= 1'b0;
            if (accept && !cmd_kind) begin
                alu_op       <= cmd_op;
                rf_addr_out0 <= cmd_a;
                rf_addr_out1 <= cmd_b;
            end
            if (accept && cmd_kind) begin
                rf_en_in   <= dest_ok(cmd_d);
                rf_addr_in <= cmd_d;
                rf_data_in <= imm_ext;
            end
            if (wait_last) begin
                rf_en_in   <= (op_q != ALU_NOP) && dest_ok(d_q);
                rf_addr_in <= d_q;
                rf_data_in <= alu_res;
                if (op_q != ALU_NOP) begin
                    flags <= {alu_zf, alu_cf, alu_of, alu_sf};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
//------------------------------------------------------------------------------
// tb_alu_issue_ctrl : directed bench with reg_file/alu models around two DUTs
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;

    // DUT0: ALU_LAT=1 with reg_file and alu models
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_kind = 1'b0;
    alu_op_t     cmd_op = ALU_NOP;
    logic [3:0]  cmd_a = '0, cmd_b = '0, cmd_d = '0;
    logic [15:0] cmd_imm = '0;
    logic [3:0]  rf_addr_out0, rf_addr_out1, rf_addr_in;
    logic        rf_en_in;
    logic [63:0] rf_data_in;
    alu_op_t     alu_op;
    logic [63:0] alu_res;
    logic        alu_zf, alu_cf, alu_of, alu_sf;
    logic [3:0]  flags;
    logic        done, busy;

    // DUT1: ALU_LAT=3, handshake timing only
    logic        cmd_valid1 = 1'b0;
    logic        cmd_ready1;
    logic        cmd_kind1 = 1'b0;
    alu_op_t     cmd_op1 = ALU_NOP;
    logic [3:0]  a1, b1, ai1, d1 = '0;
    logic        en1;
    logic [63:0] data1;
    alu_op_t     aop1;
    logic [3:0]  flags1;
    logic        done1, busy1;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.REG_DEPTH(16), .REG_WIDTH(64), .IMM_WIDTH(16), .ALU_LAT(1), .ZERO_REG(1)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_imm(cmd_imm),
        .rf_addr_out0(rf_addr_out0), .rf_addr_out1(rf_addr_out1), .rf_en_in(rf_en_in),
        .rf_addr_in(rf_addr_in), .rf_data_in(rf_data_in), .alu_op(alu_op), .alu_res(alu_res),
        .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_of(alu_of), .alu_sf(alu_sf),
        .flags(flags), .done(done), .busy(busy)
    );

    alu_issue_ctrl #(.REG_DEPTH(16), .REG_WIDTH(64), .IMM_WIDTH(16), .ALU_LAT(3), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_kind(cmd_kind1),
        .cmd_op(cmd_op1), .cmd_a(4'd1), .cmd_b(4'd2), .cmd_d(d1), .cmd_imm(16'h0042),
        .rf_addr_out0(a1), .rf_addr_out1(b1), .rf_en_in(en1),
        .rf_addr_in(ai1), .rf_data_in(data1), .alu_op(aop1), .alu_res(64'h0),
        .alu_zf(1'b0), .alu_cf(1'b0), .alu_of(1'b0), .alu_sf(1'b0),
        .flags(flags1), .done(done1), .busy(busy1)
    );

    // reg_file model: combinational read, write at edge
    logic [63:0] rf [16];
    always @(posedge clk) if (rf_en_in) rf[rf_addr_in] <= rf_data_in;

    // alu model, one cycle of latency
    logic [63:0] op_a, op_b, r_c;
    logic        c_c, o_c;
    always_comb begin
        op_a = rf[rf_addr_out0];
        op_b = rf[rf_addr_out1];
        r_c  = '0;
        c_c  = 1'b0;
        o_c  = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                {c_c, r_c} = {1'b0, op_a} + {1'b0, op_b};
                o_c = (op_a[63] == op_b[63]) && (r_c[63] != op_a[63]);
            end
            ALU_SUB: begin
                {c_c, r_c} = {1'b0, op_a} - {1'b0, op_b};
                o_c = (op_a[63] != op_b[63]) && (r_c[63] != op_a[63]);
            end
            ALU_AND: r_c = op_a & op_b;
            ALU_OR:  r_c = op_a | op_b;
            ALU_XOR: r_c = op_a ^ op_b;
            default: r_c = '0;
        endcase
    end
    always @(posedge clk) begin
        alu_res <= r_c;
        alu_zf  <= (r_c == 64'd0);
        alu_cf  <= c_c;
        alu_of  <= o_c;
        alu_sf  <= r_c[63];
    end

    int wr_count = 0;
    int acc1_count = 0;
    int done1_count = 0;
    always @(posedge clk) begin
        if (rf_en_in) wr_count <= wr_count + 1;
        if (cmd_valid1 && cmd_ready1) acc1_count <= acc1_count + 1;
        if (done1) done1_count <= done1_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left on a negedge; accept edge T is the next posedge.
    task automatic do_ldi(input logic [3:0] d, input logic [15:0] imm,
                          input logic [63:0] exp_data, input logic [3:0] exp_flags);
        check("ldi_ready", cmd_ready, 1);
        cmd_valid = 1; cmd_kind = 1; cmd_d = d; cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 0;
        check("ldi_wb_en", rf_en_in, 1);
        check("ldi_wb_addr", rf_addr_in, d);
        check("ldi_wb_data", rf_data_in, exp_data);
        check("ldi_done", done, 1);
        check("ldi_busy", busy, 1);
        check("ldi_flags", flags, exp_flags);
        @(negedge clk);
        check("ldi_ready_back", cmd_ready, 1);
        check("ldi_done_low", done, 0);
    endtask

    task automatic do_alu(input alu_op_t op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] d, input logic exp_en,
                          input logic [63:0] exp_data, input logic [3:0] exp_flags);
        int wc0;
        wc0 = wr_count;
        check("alu_ready", cmd_ready, 1);
        cmd_valid = 1; cmd_kind = 0; cmd_op = op; cmd_a = a; cmd_b = b; cmd_d = d;
        @(negedge clk);
        cmd_valid = 0;
        check("issue_op", alu_op, op);
        check("issue_a", rf_addr_out0, a);
        check("issue_b", rf_addr_out1, b);
        check("issue_ready", cmd_ready, 0);
        @(negedge clk);
        check("wait_op_nop", alu_op, ALU_NOP);
        check("wait_en", rf_en_in, 0);
        @(negedge clk);
        check("wb_en", rf_en_in, exp_en);
        check("wb_data", rf_en_in ? rf_data_in : exp_data, exp_data);
        check("wb_done", done, 1);
        check("wb_flags", flags, exp_flags);
        check("wb_ready", cmd_ready, 0);
        @(negedge clk);
        check("alu_ready_back", cmd_ready, 1);
        check("alu_done_low", done, 0);
        check("alu_writes", wr_count - wc0, exp_en ? 1 : 0);
    endtask

    initial begin
        int acc[3];
        int idx;
        int wc;
        logic will;

        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_ready", cmd_ready, 1);
        check("rst_en", rf_en_in, 0);
        check("rst_addr_in", rf_addr_in, 0);
        check("rst_data_in", rf_data_in, 0);
        check("rst_addr_out0", rf_addr_out0, 0);
        check("rst_alu_op", alu_op, ALU_NOP);
        check("rst_flags", flags, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);

        do_ldi(4'd1, 16'hffff, 64'hffff_ffff_ffff_ffff, 4'b0000);
        do_ldi(4'd2, 16'h5678, 64'h0000_0000_0000_5678, 4'b0000);
        do_alu(ALU_ADD, 4'd1, 4'd2, 4'd3, 1, 64'h5677, 4'b0100);
        do_alu(ALU_SUB, 4'd2, 4'd1, 4'd3, 1, 64'h5679, 4'b0100);
        do_alu(ALU_SUB, 4'd1, 4'd1, 4'd3, 1, 64'h0, 4'b1000);
        do_ldi(4'd4, 16'h8000, 64'hffff_ffff_ffff_8000, 4'b1000);
        do_alu(ALU_ADD, 4'd1, 4'd1, 4'd0, 0, 64'hffff_ffff_ffff_fffe, 4'b0101);
        do_alu(ALU_NOP, 4'd1, 4'd2, 4'd6, 0, 64'h0, 4'b0101);

        // reset during WAIT of an ADD
        wc = wr_count;
        cmd_valid = 1; cmd_kind = 0; cmd_op = ALU_ADD; cmd_a = 4'd2; cmd_b = 4'd2; cmd_d = 4'd7;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mrst_en", rf_en_in, 0);
        check("mrst_flags", flags, 0);
        check("mrst_ready", cmd_ready, 1);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        @(negedge clk);
        check("mrst_no_write", wr_count - wc, 0);
        do_ldi(4'd5, 16'h0001, 64'h1, 4'b0000);

        // DUT1: three back-to-back commands, cmd_valid held high
        acc = '{default: 0};
        idx = 0;
        cmd_valid1 = 1;
        for (int c = 0; c < 60 && idx < 3; c++) begin
            cmd_kind1 = (idx == 1);
            cmd_op1   = (idx == 2) ? ALU_SUB : ALU_ADD;
            d1        = 4'(idx + 8);
            will      = cmd_ready1;
            if (will) acc[idx] = c;
            @(negedge clk);
            if (will) idx++;
        end
        cmd_valid1 = 0;
        check("q_all_accepted", idx, 3);
        check("q_alu_spacing", acc[1] - acc[0], 6);
        check("q_ldi_spacing", acc[2] - acc[1], 2);
        repeat (10) @(negedge clk);
        check("q_accept_count", acc1_count, 3);
        check("q_done_count", done1_count, 3);
        check("q_idle", busy1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
